// File: rtl/spike_enc_pkg.sv
// Shared definitions for the Poisson spike encoder: FSM states and default sizes.
package spike_enc_pkg;

  localparam int NUM_CH = 8;
  localparam int RATE_W = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } enc_state_t;

endpackage

// File: rtl/spike_rate_regfile.sv
// Per-channel firing-rate registers. Writes land on the clock edge and the
// read port is combinational, so a compare in the same cycle as a write to
// that channel still sees the old rate.
module spike_rate_regfile #(
  parameter int NUM_CH = spike_enc_pkg::NUM_CH,
  parameter int RATE_W = spike_enc_pkg::RATE_W,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [CH_W-1:0]   waddr,
  input  logic [RATE_W-1:0] wdata,
  input  logic [CH_W-1:0]   raddr,
  output logic [RATE_W-1:0] rdata
);

  logic [RATE_W-1:0] rate_q [NUM_CH];

  // Rate storage: cleared on reset, otherwise one write per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rate_q[i] <= '0;
      end
    end else if (we) begin
      rate_q[waddr] <= wdata;
    end
  end

  assign rdata = rate_q[raddr];

endmodule

// File: rtl/poisson_spike_encoder.sv
// Rate-coded input stage: once per time step every channel's rate is compared
// against the incoming random word and each firing channel emits one event
// over a valid/ready interface.
// Optional feature macro: SPIKE_CNT_EN adds a saturating per-step spike count
// output spike_cnt.
module poisson_spike_encoder
  import spike_enc_pkg::*;
#(
  parameter int NUM_CH = spike_enc_pkg::NUM_CH,
  parameter int RATE_W = spike_enc_pkg::RATE_W,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [RATE_W-1:0] rnd,
  input  logic              rate_we,
  input  logic [CH_W-1:0]   rate_addr,
  input  logic [RATE_W-1:0] rate_wdata,
  input  logic              step_start,
  output logic              busy,
  output logic              step_done,
  output logic              spike_valid,
  output logic [CH_W-1:0]   spike_ch,
  input  logic              spike_ready
`ifdef SPIKE_CNT_EN
  ,
  output logic [15:0]       spike_cnt
`endif
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  enc_state_t        state, state_next;
  logic [CH_W-1:0]   ch, ch_next;
  logic [CH_W-1:0]   spike_ch_q, spike_ch_next;
  logic [RATE_W-1:0] rate_rd;
  logic              hit;
  logic              last_ch;

  spike_rate_regfile #(
    .NUM_CH (NUM_CH),
    .RATE_W (RATE_W),
    .CH_W   (CH_W)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (rate_we),
    .waddr (rate_addr),
    .wdata (rate_wdata),
    .raddr (ch),
    .rdata (rate_rd)
  );

  assign hit     = (rnd < rate_rd);
  assign last_ch = (ch == LAST_CH);

  // State, channel pointer and latched event channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ch         <= '0;
      spike_ch_q <= '0;
    end else begin
      state      <= state_next;
      ch         <= ch_next;
      spike_ch_q <= spike_ch_next;
    end
  end

  // Next-state logic: walk the channels, pausing in EMIT until each event is taken.
  always_comb begin
    state_next    = state;
    ch_next       = ch;
    spike_ch_next = spike_ch_q;
    case (state)
      IDLE: begin
        if (step_start) begin
          state_next = SCAN;
          ch_next    = '0;
        end
      end
      SCAN: begin
        if (hit) begin
          spike_ch_next = ch;
          state_next    = EMIT;
        end else if (last_ch) begin
          state_next = DONE;
        end else begin
          ch_next = ch + 1'b1;
        end
      end
      EMIT: begin
        if (spike_ready) begin
          if (last_ch) begin
            state_next = DONE;
          end else begin
            ch_next    = ch + 1'b1;
            state_next = SCAN;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy        = (state != IDLE);
  assign step_done   = (state == DONE);
  assign spike_valid = (state == EMIT);
  assign spike_ch    = spike_ch_q;

`ifdef SPIKE_CNT_EN
  logic [15:0] cnt_q;

  // Count handshakes within a step and publish the total when the step ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      spike_cnt <= '0;
    end else begin
      if (state == IDLE && step_start) begin
        cnt_q <= '0;
      end else if (state == EMIT && spike_ready && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (state == DONE) begin
        spike_cnt <= cnt_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Self-checking bench for poisson_spike_encoder. The reference walks each step
// channel by channel using the rule "fire when rnd < rate", tracking its own
// copy of the rate table. Build with SPIKE_CNT_EN to also check spike_cnt.
module tb_poisson_spike_encoder;

  localparam int NUM_CH = spike_enc_pkg::NUM_CH;
  localparam int RATE_W = spike_enc_pkg::RATE_W;
  localparam int CH_W   = $clog2(NUM_CH);

  logic              clock = 1'b0;
  logic              reset;
  logic [RATE_W-1:0] rnd;
  logic              rate_we;
  logic [CH_W-1:0]   rate_addr;
  logic [RATE_W-1:0] rate_wdata;
  logic              step_start;
  logic              busy;
  logic              step_done;
  logic              spike_valid;
  logic [CH_W-1:0]   spike_ch;
  logic              spike_ready;
`ifdef SPIKE_CNT_EN
  logic [15:0]       spike_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int totalSpikes = 0;
  int stepSpikes;

  logic [RATE_W-1:0] modelRate [NUM_CH];
  logic [12:0]       lfsr = 13'h0001;

  poisson_spike_encoder dut (
    .clock       (clock),
    .reset       (reset),
    .rnd         (rnd),
    .rate_we     (rate_we),
    .rate_addr   (rate_addr),
    .rate_wdata  (rate_wdata),
    .step_start  (step_start),
    .busy        (busy),
    .step_done   (step_done),
    .spike_valid (spike_valid),
    .spike_ch    (spike_ch),
    .spike_ready (spike_ready)
`ifdef SPIKE_CNT_EN
    ,
    .spike_cnt   (spike_cnt)
`endif
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // 13-bit maximal-length Fibonacci LFSR (taps 13,4,3,1).
  function automatic logic [12:0] lfsrNext(input logic [12:0] s);
    logic fb;
    fb = s[12] ^ s[3] ^ s[2] ^ s[0];
    return {s[11:0], fb};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic writeRate(input int c, input logic [RATE_W-1:0] v);
    rate_we    = 1'b1;
    rate_addr  = CH_W'(c);
    rate_wdata = v;
    @(posedge clock);
    @(negedge clock);
    rate_we      = 1'b0;
    modelRate[c] = v;
  endtask

  task automatic writeAll(input logic [RATE_W-1:0] v);
    for (int c = 0; c < NUM_CH; c++) writeRate(c, v);
  endtask

  // Run one full step starting from IDLE at a falling edge.
  // mode: 0 fixed rnd, 1 alternating 0/5000, 2 $urandom, 3 LFSR.
  task automatic applyStimulus(input int mode, input logic [RATE_W-1:0] fixRnd,
                               input int stallFirst, input bit stallRand,
                               input int wrCh, input logic [RATE_W-1:0] wrVal,
                               input int pokeCh, output int spikes);
    int   stall;
    bit   first;
    bit   hit;
    int   count;
    logic [RATE_W-1:0] r;
    first = 1'b1;
    count = 0;
    step_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    step_start = 1'b0;
    checkOutput("busy_scan0", busy, 1);
    for (int c = 0; c < NUM_CH; c++) begin
      case (mode)
        0: r = fixRnd;
        1: r = (c % 2 == 0) ? 13'd0 : 13'd5000;
        2: r = RATE_W'($urandom_range(0, 8191));
        default: begin
          lfsr = lfsrNext(lfsr);
          r    = lfsr;
        end
      endcase
      rnd = r;
      if (c == wrCh) begin
        rate_we    = 1'b1;
        rate_addr  = CH_W'(c);
        rate_wdata = wrVal;
      end
      if (c == pokeCh) step_start = 1'b1;
      hit = (r < modelRate[c]);
      @(posedge clock);
      @(negedge clock);
      rate_we    = 1'b0;
      step_start = 1'b0;
      if (c == wrCh) modelRate[c] = wrVal;
      checkOutput("spike_valid", spike_valid, hit);
      if (hit) begin
        checkOutput("spike_ch", spike_ch, c);
        checkOutput("busy_emit", busy, 1);
        stall = first ? stallFirst : (stallRand ? $urandom_range(0, 3) : 0);
        first = 1'b0;
        repeat (stall) begin
          spike_ready = 1'b0;
          @(posedge clock);
          @(negedge clock);
          checkOutput("stall_valid", spike_valid, 1);
          checkOutput("stall_ch", spike_ch, c);
          checkOutput("stall_done", step_done, 0);
        end
        spike_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        count++;
        checkOutput("valid_drop", spike_valid, 0);
        if (c != NUM_CH - 1) checkOutput("done_early", step_done, 0);
      end else if (c != NUM_CH - 1) begin
        checkOutput("done_early", step_done, 0);
      end
    end
    checkOutput("step_done", step_done, 1);
    checkOutput("busy_done", busy, 1);
    @(posedge clock);
    @(negedge clock);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", step_done, 0);
`ifdef SPIKE_CNT_EN
    checkOutput("spike_cnt", spike_cnt, count);
`endif
    spikes = count;
  endtask

  // Directed and randomized sequence.
  initial begin
    reset       = 1'b1;
    rnd         = '0;
    rate_we     = 1'b0;
    rate_addr   = '0;
    rate_wdata  = '0;
    step_start  = 1'b0;
    spike_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) modelRate[c] = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", step_done, 0);
    checkOutput("rst_valid", spike_valid, 0);
    checkOutput("rst_ch", spike_ch, 0);
`ifdef SPIKE_CNT_EN
    checkOutput("rst_cnt", spike_cnt, 0);
`endif
    repeat (3) @(negedge clock);
    checkOutput("idle_quiet", busy, 0);

    $display("[TB] all rates zero");
    applyStimulus(0, 13'd0, 0, 1'b0, -1, 13'd0, -1, stepSpikes);

    $display("[TB] single channel at max rate");
    writeRate(3, 13'd8191);
    applyStimulus(0, 13'd100, 0, 1'b0, -1, 13'd0, -1, stepSpikes);
    applyStimulus(0, 13'd8191, 0, 1'b0, -1, 13'd0, -1, stepSpikes);

    $display("[TB] half rate, alternating rnd, stalled first event");
    writeAll(13'd4096);
    applyStimulus(1, 13'd0, 5, 1'b0, -1, 13'd0, -1, stepSpikes);
    applyStimulus(0, 13'd4095, 2, 1'b1, -1, 13'd0, -1, stepSpikes);
    applyStimulus(0, 13'd4096, 0, 1'b0, -1, 13'd0, -1, stepSpikes);

    $display("[TB] rate boundaries");
    writeAll(13'd8191);
    applyStimulus(0, 13'd8191, 0, 1'b0, -1, 13'd0, -1, stepSpikes);
    applyStimulus(0, 13'd8190, 0, 1'b1, -1, 13'd0, -1, stepSpikes);
    writeAll(13'd0);
    applyStimulus(0, 13'd0, 0, 1'b0, -1, 13'd0, -1, stepSpikes);

    $display("[TB] write during compare");
    applyStimulus(0, 13'd10, 0, 1'b0, 5, 13'd8191, -1, stepSpikes);
    applyStimulus(0, 13'd10, 0, 1'b0, -1, 13'd0, -1, stepSpikes);
    writeRate(2, 13'd8191);
    applyStimulus(0, 13'd10, 0, 1'b0, 2, 13'd0, -1, stepSpikes);
    applyStimulus(0, 13'd10, 0, 1'b0, -1, 13'd0, -1, stepSpikes);

    $display("[TB] step_start while busy");
    writeAll(13'd4096);
    applyStimulus(2, 13'd0, 1, 1'b1, -1, 13'd0, 4, stepSpikes);
    applyStimulus(2, 13'd0, 0, 1'b0, -1, 13'd0, 7, stepSpikes);

    $display("[TB] randomized rates");
    for (int s = 0; s < 20; s++) begin
      for (int c = 0; c < NUM_CH; c++) writeRate(c, RATE_W'($urandom_range(0, 8191)));
      applyStimulus(2, 13'd0, $urandom_range(0, 3), 1'b1,
                    $urandom_range(0, NUM_CH - 1), RATE_W'($urandom_range(0, 8191)),
                    -1, stepSpikes);
    end

    $display("[TB] reset during EMIT");
    writeAll(13'd8191);
    rnd        = 13'd0;
    step_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    step_start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("emit_before_rst", spike_valid, 1);
    spike_ready = 1'b0;
    reset       = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset       = 1'b0;
    spike_ready = 1'b1;
    checkOutput("rst_emit_valid", spike_valid, 0);
    checkOutput("rst_emit_busy", busy, 0);
    checkOutput("rst_emit_ch", spike_ch, 0);
`ifdef SPIKE_CNT_EN
    checkOutput("rst_emit_cnt", spike_cnt, 0);
`endif
    for (int c = 0; c < NUM_CH; c++) modelRate[c] = '0;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput("rst_emit_nodone", step_done, 0);
    end
    applyStimulus(0, 13'd0, 0, 1'b0, -1, 13'd0, -1, stepSpikes);

    $display("[TB] LFSR statistical run");
    writeAll(13'd2048);
    totalSpikes = 0;
    for (int s = 0; s < 2000; s++) begin
      applyStimulus(3, 13'd0, 0, 1'b0, -1, 13'd0, -1, stepSpikes);
      totalSpikes += stepSpikes;
    end
    $display("[TB] spikes %0d of %0d samples", totalSpikes, 2000 * NUM_CH);
    checkOutput("lfsr_fraction",
                (totalSpikes >= (2000 * NUM_CH * 22) / 100) &&
                (totalSpikes <= (2000 * NUM_CH * 28) / 100), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
